// File: rtl/vedic_mul16_seq.sv
// vedic_mul16_seq: sequenced 16x16 unsigned multiplier.
// One 8x8 vedic core is reused over four cycles; each step adds one shifted
// 8x8 partial product into a 32-bit accumulator.
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   in_valid  - a/b presented          in_ready  - operands accepted (IDLE)
//   a, b      - 16-bit unsigned operands
//   out_valid - prod is final (DONE)   out_ready - consumer takes the result
//   prod      - 32-bit product, straight from the accumulator register
//   busy      - high in MUL or DONE
//
// Optional feature: define VEDIC_MUL16_EARLY_ZERO_EN to finish a multiply
// whose captured operand is zero after one cycle instead of four.

module vedic8x8 (
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic [15:0] p
);
  logic [7:0] p_ll, p_lh, p_hl, p_hh;

  // Four 4x4 vertical/crosswise products, recombined at their nibble weights.
  assign p_ll = {4'h0, x[3:0]} * {4'h0, y[3:0]};
  assign p_lh = {4'h0, x[3:0]} * {4'h0, y[7:4]};
  assign p_hl = {4'h0, x[7:4]} * {4'h0, y[3:0]};
  assign p_hh = {4'h0, x[7:4]} * {4'h0, y[7:4]};

  assign p = {8'h00, p_ll} + {4'h0, p_lh, 4'h0} + {4'h0, p_hl, 4'h0} + {p_hh, 8'h00};
endmodule

module vedic_mul16_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] prod,
  output logic        busy
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [31:0] acc_q, acc_d;
  logic [15:0] a_q, a_d, b_q, b_d;

  logic [7:0]  core_x, core_y;
  logic [15:0] pp;
  logic [31:0] pp_ext;

  // step[1] picks the high byte of a, step[0] the high byte of b:
  // 0 -> lo*lo, 1 -> lo*hi, 2 -> hi*lo, 3 -> hi*hi.
  assign core_x = step_q[1] ? a_q[15:8] : a_q[7:0];
  assign core_y = step_q[0] ? b_q[15:8] : b_q[7:0];

  vedic8x8 u_core (
    .x (core_x),
    .y (core_y),
    .p (pp)
  );

  always_comb begin
    pp_ext = 32'h0;
    case (step_q)
      2'd0:    pp_ext = {16'h0000, pp};
      2'd1,
      2'd2:    pp_ext = {8'h00, pp, 8'h00};
      default: pp_ext = {pp, 16'h0000};
    endcase
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = 32'h0;
          step_d  = 2'd0;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        acc_d  = acc_q + pp_ext;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) state_d = ST_DONE;
`ifdef VEDIC_MUL16_EARLY_ZERO_EN
        // A zero operand makes the product zero; leave after the first step.
        if ((step_q == 2'd0) && ((a_q == 16'h0) || (b_q == 16'h0))) begin
          acc_d   = 32'h0;
          step_d  = 2'd0;
          state_d = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= 2'd0;
      acc_q   <= 32'h0;
      a_q     <= 16'h0;
      b_q     <= 16'h0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign prod      = acc_q;
endmodule

// File: tb/tb_vedic_mul16_seq.sv
module tb_vedic_mul16_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = 16'h0;
  logic [15:0] b = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] prod;
  logic        busy;

  int checks = 0;
  int errors = 0;

`ifdef VEDIC_MUL16_EARLY_ZERO_EN
  localparam int LAT_ZERO = 1;
`else
  localparam int LAT_ZERO = 4;
`endif

  vedic_mul16_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] xx, yy;
    xx = {16'h0, x};
    yy = {16'h0, y};
    return xx * yy;
  endfunction

  // Presents one operand pair for exactly one rising edge (block assumed idle).
  task automatic accept(input logic [15:0] av, input logic [15:0] bv);
    @(negedge clk);
    in_valid = 1'b1;
    a = av;
    b = bv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || prod !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b prod=%h, required 1 0 0 00000000",
               in_ready, out_valid, busy, prod);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_op(input string name, input logic [15:0] av, input logic [15:0] bv,
                         input int lat, input logic [31:0] expv);
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_before: in_ready=%b required 1", name, in_ready);
    end
    accept(av, bv);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_wait%0d: out_valid=%b busy=%b in_ready=%b required 0 1 0",
                 name, i, out_valid, busy, in_ready);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || prod !== expv) begin
      errors++;
      $display("FAIL %s_result: out_valid=%b prod=%h required 1 %h", name, out_valid, prod, expv);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || prod !== expv) begin
      errors++;
      $display("FAIL %s_release: in_ready=%b out_valid=%b busy=%b prod=%h required 1 0 0 %h",
               name, in_ready, out_valid, busy, prod, expv);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    accept(16'h00FF, 16'h0100);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 16'($urandom);
      b = 16'($urandom);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || prod !== 32'h0000FF00) begin
        errors++;
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b prod=%h required 1 0 0000ff00",
                 i, out_valid, in_ready, prod);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || prod !== 32'h0000FF00) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b prod=%h required 1 0 0000ff00",
               in_ready, out_valid, prod);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    accept(16'hAAAA, 16'h5555);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || prod !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b busy=%b prod=%h required 1 0 0 00000000",
               in_ready, out_valid, busy, prod);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_op("after_reset", 16'd3, 16'd5, 4, 32'h0000000F);
  endtask

  task automatic test_back_to_back();
    localparam int N = 1000;
    logic [31:0] expq[$];
    logic [31:0] e;
    int sent = 0;
    int recv = 0;
    int cycles = 0;
    bit fired = 1'b0;
    while (recv < N && cycles < 60000) begin
      @(negedge clk);
      cycles++;
      if (fired) begin
        in_valid = 1'b0;
        fired = 1'b0;
      end
      if (sent < N && !in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        a = 16'($urandom);
        b = 16'($urandom);
        if ($urandom_range(0, 15) == 0) a = 16'hFFFF;
        if ($urandom_range(0, 15) == 0) b = 16'h0000;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: unexpected result prod=%h with no outstanding operands", prod);
        end else begin
          e = expq.pop_front();
          if (prod !== e) begin
            errors++;
            $display("FAIL b2b_prod%0d: prod=%h required %h", recv, prod, e);
          end
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(ref_mul(a, b));
        sent++;
        fired = 1'b1;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (recv != N || expq.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: received=%0d outstanding=%0d required %0d and 0",
               recv, expq.size(), N);
    end
  endtask

  initial begin
    test_reset();
    test_op("single", 16'h1234, 16'h5678, 4, 32'h06260060);
    test_op("max", 16'hFFFF, 16'hFFFF, 4, 32'hFFFE0001);
    test_op("lo_hi", 16'h00FF, 16'hFF00, 4, 32'h00FE0100);
    test_backpressure();
    test_reset_mid();
    test_op("zero", 16'h0000, 16'hBEEF, LAT_ZERO, 32'h0);
    test_op("nonzero_after_zero", 16'h0001, 16'hBEEF, 4, 32'h0000BEEF);
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
